seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_div_pkg.sv | 21 ++
 rtl/div_step.sv | 41 ++++
 rtl/seq_divider.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_pkg
// Description : Shared definitions for the sequential restoring divider:
//               FSM state encoding and default operand widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_div_pkg;

    localparam int DVD_W_DEF = 8;   // dividend / quotient width
    localparam int DVS_W_DEF = 4;   // divisor / remainder width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division step. Subtracts the divisor from the
//               shifted partial remainder with a ripple chain of full-adder
//               cells (minuend + ~subtrahend + 1). The final carry-out is the
//               no-borrow flag, which is also the quotient bit.
// Ports       : i_minuend    - shifted partial remainder (WIDTH bits)
//               i_subtrahend - zero-extended divisor     (WIDTH bits)
//               o_diff       - i_minuend - i_subtrahend  (WIDTH bits)
//               o_no_borrow  - 1 when i_minuend >= i_subtrahend
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DVS_W_DEF + 1
) (
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_no_borrow
);

    // Carry-in of 1 completes the two's-complement negation of the subtrahend.
    logic [WIDTH:0] w_carry;
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_b_inv;
        logic w_p;
        assign w_b_inv        = ~i_subtrahend[i];
        assign w_p            = i_minuend[i] ^ w_b_inv;
        assign o_diff[i]      = w_p ^ w_carry[i];
        assign w_carry[i + 1] = (i_minuend[i] & w_b_inv) | (w_carry[i] & w_p);
    end

    assign o_no_borrow = w_carry[WIDTH];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned sequential restoring divider, one quotient bit per
//               clock, MSB first. Divide-by-zero completes immediately with
//               quotient all ones and remainder = low dividend bits.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               start     - division request, sampled only in IDLE
//               dividend  - unsigned dividend  (DVD_W)
//               divisor   - unsigned divisor   (DVS_W)
//               quotient  - registered quotient  (DVD_W)
//               remainder - registered remainder (DVS_W)
//               busy      - high while an operation is in flight
//               done      - one-cycle result-valid pulse
//               div_zero  - high with done when divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int                 C_CNT_W    = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DVD_W - 1);

    state_t             r_state;
    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after DVD_W steps this register holds the quotient.
    logic [DVD_W-1:0]   r_dvd;
    logic [DVS_W-1:0]   r_dvs;
    logic [DVS_W-1:0]   r_prem;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_zero;

    logic [DVS_W:0]     w_shifted;
    logic [DVS_W:0]     w_diff;
    logic [DVS_W:0]     w_next_prem;
    logic               w_qbit;
    logic               w_unused;

    assign w_shifted = {r_prem, r_dvd[DVD_W-1]};

    div_step #(
        .WIDTH (DVS_W + 1)
    ) u_step (
        .i_minuend    (w_shifted),
        .i_subtrahend ({1'b0, r_dvs}),
        .o_diff       (w_diff),
        .o_no_borrow  (w_qbit)
    );

    // Restore on borrow. The kept remainder is always below the divisor, so
    // its top bit is structurally zero and only DVS_W bits are stored.
    assign w_next_prem = w_qbit ? w_diff : w_shifted;
    assign w_unused    = w_next_prem[DVS_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_prem    <= '0;
            r_cnt     <= '0;
            r_zero    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            // Status outputs are registered from the current state, so they
            // trail the state by one clock.
            busy <= (r_state != IDLE);
            done <= (r_state == DONE);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_prem  <= '0;
                        r_cnt   <= C_CNT_LAST;
                        r_zero  <= (divisor == '0);
                        r_state <= (divisor == '0) ? DONE : RUN;
                    end
                end

                RUN: begin
                    r_dvd  <= {r_dvd[DVD_W-2:0], w_qbit};
                    r_prem <= w_next_prem[DVS_W-1:0];
                    if (r_cnt == '0) begin
                        quotient  <= {r_dvd[DVD_W-2:0], w_qbit};
                        remainder <= w_next_prem[DVS_W-1:0];
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end

                DONE: begin
                    div_zero <= r_zero;
                    if (r_zero) begin
                        quotient  <= '1;
                        remainder <= r_dvd[DVS_W-1:0];
                    end
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : seq_divider
`default_nettype wire
